input_skew_feeder: RTL
======================

Name: input_skew_feeder

Overview:
- Transmit-side companion to the systolic array's output collector.
- Accepts one N x N operand pair (matrix A and matrix B) through a valid/ready handshake, then streams it into the array edges in diagonal-skewed order over 2N-1 feed steps.
- Row lane i carries A row i, delayed i steps; column lane j carries B column j, delayed j steps.
- A per-lane valid qualifies every element, and a done pulse marks the end of the stream.

Parameters:
- N, 3, array dimension (N >= 2); the feed sequence lasts 2N-1 steps.
- DATA_WIDTH, 8, operand element width in bits.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair on a_in/b_in is valid.
- in_ready  output  1  feeder can accept an operand pair.
- a_in  input  [DATA_WIDTH-1:0] x [0:N-1][0:N-1]  matrix A, indexed [row][col].
- b_in  input  [DATA_WIDTH-1:0] x [0:N-1][0:N-1]  matrix B, indexed [row][col].
- feed_en  input  1  advance enable; 0 freezes the feed sequence.
- a_out  output  [DATA_WIDTH-1:0] x [0:N-1]  left-edge row lanes.
- a_valid  output  [0:N-1]  per-row-lane valid.
- b_out  output  [DATA_WIDTH-1:0] x [0:N-1]  top-edge column lanes.
- b_valid  output  [0:N-1]  per-column-lane valid.
- busy  output  1  high in the FEED state.
- done  output  1  one-cycle pulse after the last feed step.

Behaviour:
- Storage: internal registers A_r, B_r (N x N each); step counter cnt, width clog2(2N-1), range 0..2N-2.
- FSM states: IDLE, FEED.
- Reset (asynchronous, active-low): state = IDLE, cnt = 0, A_r/B_r = 0, done = 0. Consequently in_ready = 1, busy = 0, and all lane outputs and valids = 0.
- Handshake:
  - in_ready = (state == IDLE), decoded from state only; it never depends on in_valid.
  - A transfer occurs on an edge where in_valid && in_ready.
  - On that edge: A_r <= a_in, B_r <= b_in, cnt <= 0, state <= FEED.
  - Data presented while in_ready = 0 is ignored; it is neither captured nor queued.
- Lane decode: combinational from registers only (state, cnt, A_r, B_r); never from inputs. In FEED with cnt = t and feed_en = 1:
  - a_valid[i] = (i <= t <= i+N-1); a_out[i] = A_r[i][t-i] when valid, else 0.
  - b_valid[j] = (j <= t <= j+N-1); b_out[j] = B_r[t-j][j] when valid, else 0.
- feed_en = 0 in FEED: cnt holds, all valids = 0, all lane data = 0 (bubble).
- Any cycle outside FEED: all lane data and valids = 0.
- Advance: each edge in FEED with feed_en = 1 increments cnt.
- Termination: on the edge where cnt == 2N-2 and feed_en = 1:
  - state <= IDLE, cnt <= 0, done <= 1 (for exactly one cycle).
  - in_ready is therefore 1 in the same cycle that done = 1, so the next transfer can be taken in the done cycle.
  - Turnaround from one stream to the next: one idle cycle minimum.
- Latency:
  - The step-0 lanes are visible in the cycle immediately after the transfer edge.
  - Without stalls, the stream occupies exactly 2N-1 consecutive cycles, then done.
- Totals: each lane carries exactly N valid elements per stream; across both edges that is 2N^2 element-beats.
- busy = (state == FEED).
- Mid-operation reset: an asynchronous assertion immediately zeroes all outputs and returns the FSM to IDLE. The partially fed matrix is discarded and no done pulse is issued.
- Edge case: in_valid held high continuously is legal. A new transfer occurs only in IDLE cycles, including the done cycle.

Test Plan:
- Reset behaviour: assert rst_n = 0 mid-clock -> in_ready = 1, busy = 0, done = 0, all valids 0, without waiting for a clock edge.
- Basic feed, N=3, A = [[1,2,3],[4,5,6],[7,8,9]], B = [[10,11,12],[13,14,15],[16,17,18]], feed_en = 1 -> per step:
  - step 0: a_out {1,0,0}, a_valid 100; b_out {10,0,0}, b_valid 100.
  - step 1: a_out {2,4,0}, a_valid 110; b_out {13,11,0}, b_valid 110.
  - step 2: a_out {3,5,7}, a_valid 111; b_out {16,14,12}, b_valid 111.
  - step 4: a_out {0,0,9}, a_valid 001; b_out {0,0,18}, b_valid 001.
  - done is high in the 6th cycle after the transfer edge.
- Stall: drop feed_en for 2 cycles at step 2 -> valids 0 for 2 cycles, then step 2 repeats with identical values; done is delayed by exactly 2 cycles.
- Back-to-back: hold in_valid = 1 with a second pair -> the second transfer occurs in the done cycle; its step 0 appears the next cycle; in_ready = 0 throughout FEED.
- Reset during FEED at step 3 -> outputs are 0 immediately; no done pulse; a new transfer accepted after release streams correctly from step 0.
- N=4, DATA_WIDTH=16, random matrices, scoreboard -> every lane shows N valid beats, with lane i's k-th beat equal to A[i][k] (row lanes) or B[k][i] (column lanes).

Source files
------------

// File: rtl/input_skew_feeder_if.sv
// Operand-side handshake bundle for the input skew feeder.
// The producer drives a full N x N operand pair (A and B) together with
// in_valid; the feeder answers with in_ready while it is idle.
interface input_skew_feeder_if #(
   parameter int N          = 3,
   parameter int DATA_WIDTH = 8
);

   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] a_in [N][N];
   logic [DATA_WIDTH-1:0] b_in [N][N];

   // Producer side: offers the operand pair and watches in_ready.
   modport master (
      output in_valid,
      output a_in,
      output b_in,
      input  in_ready
   );

   // Feeder side: accepts the operand pair and reports readiness.
   modport slave (
      input  in_valid,
      input  a_in,
      input  b_in,
      output in_ready
   );

endinterface

// File: rtl/input_skew_feeder.sv
// Input skew feeder for an N x N systolic array.
// Captures one A/B operand pair, then replays it onto the array edges in
// diagonal-skewed order over 2N-1 feed steps. Row lane i carries A row i
// delayed by i steps, and column lane j carries B column j delayed by j steps.
// feed_en freezes the sequence and blanks the lanes while it is low, and done
// pulses for one cycle once the last step has been fed.
module input_skew_feeder #(
   parameter int N          = 3,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input_skew_feeder_if.slave    inBus,
   input  logic                  feed_en,
   output logic [DATA_WIDTH-1:0] a_out [N],
   output logic [0:N-1]          a_valid,
   output logic [DATA_WIDTH-1:0] b_out [N],
   output logic [0:N-1]          b_valid,
   output logic                  busy,
   output logic                  done
);

   // Step counter spans 0..2N-2; element index within a row/column spans 0..N-1.
   localparam int CW = $clog2(2 * N - 1);
   localparam int IW = $clog2(N);
   localparam logic [CW-1:0] LAST_STEP = CW'(2 * N - 2);

   typedef enum logic {
      IDLE,
      FEED
   } state_t;

   state_t                r_state;
   state_t                w_nextState;
   logic [CW-1:0]         r_cnt;
   logic [CW-1:0]         w_nextCnt;
   logic                  r_done;
   logic                  w_doneNext;
   logic                  w_load;
   logic                  w_advance;
   logic [IW-1:0]         w_laneStep;
   logic [DATA_WIDTH-1:0] r_aMat [N][N];
   logic [DATA_WIDTH-1:0] r_bMat [N][N];

   // Readiness and busy come from the state alone, so a producer can
   // never create a combinational loop through in_valid.
   assign inBus.in_ready = (r_state == IDLE);
   assign busy           = (r_state == FEED);
   assign done           = r_done;

   // The sequence moves forward only while feeding with feed_en high.
   assign w_advance = (r_state == FEED) && feed_en;

   // State, step counter and done flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_nextState;
         r_cnt   <= w_nextCnt;
         r_done  <= w_doneNext;
      end
   end

   // Next-state logic: accept a pair when idle, step through the feed,
   // and return to idle with a done pulse after the final step.
   always_comb begin
      w_nextState = r_state;
      w_nextCnt   = r_cnt;
      w_doneNext  = 1'b0;
      w_load      = 1'b0;
      case (r_state)
         IDLE: begin
            if (inBus.in_valid) begin
               w_load      = 1'b1;
               w_nextState = FEED;
               w_nextCnt   = '0;
            end
         end
         FEED: begin
            if (feed_en) begin
               if (r_cnt == LAST_STEP) begin
                  w_nextState = IDLE;
                  w_nextCnt   = '0;
                  w_doneNext  = 1'b1;
               end else begin
                  w_nextCnt = r_cnt + CW'(1);
               end
            end
         end
         default: begin
            w_nextState = IDLE;
            w_nextCnt   = '0;
         end
      endcase
   end

   // Operand storage: the whole pair is captured on the accepting edge and
   // stays untouched for the rest of the stream.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
               r_aMat[r][c] <= '0;
               r_bMat[r][c] <= '0;
            end
         end
      end else if (w_load) begin
         r_aMat <= inBus.a_in;
         r_bMat <= inBus.b_in;
      end
   end

   // Lane decode: lane k is live for steps k..k+N-1 and then carries
   // element (step-k) of its row of A or column of B; all other lanes,
   // stalled cycles and non-feed cycles drive zero.
   always_comb begin
      w_laneStep = '0;
      for (int k = 0; k < N; k++) begin
         a_out[k]   = '0;
         b_out[k]   = '0;
         a_valid[k] = 1'b0;
         b_valid[k] = 1'b0;
      end
      if (w_advance) begin
         for (int k = 0; k < N; k++) begin
            if ((r_cnt >= CW'(k)) && (r_cnt <= CW'(k + N - 1))) begin
               w_laneStep = IW'(r_cnt - CW'(k));
               a_valid[k] = 1'b1;
               b_valid[k] = 1'b1;
               a_out[k]   = r_aMat[k][w_laneStep];
               b_out[k]   = r_bMat[w_laneStep][k];
            end
         end
      end
   end

endmodule
